demux1to2_stream: RTL

//   Registered 1-to-2 stream demultiplexer: the receive-side counterpart of mux2to1.

---
 rtl/demux1to2_stream_if.sv | 38 +++
 rtl/demux1to2_stream.sv | 88 ++++++++
 2 files changed

// File: rtl/demux1to2_stream_if.sv
// Stream bundle for demux1to2_stream: one input stream and two output streams.
// master = the side feeding the input and sinking both outputs; slave = the demux.
interface demux1to2_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;

  modport master (
    output in_data, in_last, in_valid,
    input  in_ready,
    input  out0_data, out0_last, out0_valid,
    output out0_ready,
    input  out1_data, out1_last, out1_valid,
    output out1_ready
  );

  modport slave (
    input  in_data, in_last, in_valid,
    output in_ready,
    output out0_data, out0_last, out0_valid,
    input  out0_ready,
    output out1_data, out1_last, out1_valid,
    input  out1_ready
  );
endinterface

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream demultiplexer. The destination is chosen by s on the
// first beat of a packet and locked until its last beat; each output has a one-entry register.
module demux1to2_stream #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s,
  output logic                busy,
  demux1to2_stream_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             dest;
  logic             ready_c;
  logic             xfer;

  logic             valid0;
  logic             last0;
  logic [WIDTH-1:0] data0;
  logic             valid1;
  logic             last1;
  logic [WIDTH-1:0] data1;

  // in_ready depends on state, s and the selected sink only, never on in_valid.
  always_comb begin
    dest      = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE:    dest = s;
      LOCK0:   dest = 1'b0;
      LOCK1:   dest = 1'b1;
      default: dest = 1'b0;
    endcase
    ready_c = dest ? (~valid1 | bus.out1_ready) : (~valid0 | bus.out0_ready);
    xfer    = bus.in_valid & ready_c;
    if (xfer) begin
      if (bus.in_last) state_nxt = IDLE;
      else             state_nxt = dest ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0 <= 1'b0;
      last0  <= 1'b0;
      data0  <= '0;
    end else if (xfer && !dest) begin
      valid0 <= 1'b1;
      last0  <= bus.in_last;
      data0  <= bus.in_data;
    end else if (bus.out0_ready) begin
      valid0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1 <= 1'b0;
      last1  <= 1'b0;
      data1  <= '0;
    end else if (xfer && dest) begin
      valid1 <= 1'b1;
      last1  <= bus.in_last;
      data1  <= bus.in_data;
    end else if (bus.out1_ready) begin
      valid1 <= 1'b0;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.out0_valid = valid0;
  assign bus.out0_last  = last0;
  assign bus.out0_data  = data0;
  assign bus.out1_valid = valid1;
  assign bus.out1_last  = last1;
  assign bus.out1_data  = data1;
  assign busy           = (state != IDLE);

endmodule
